// File: rtl/rom_wrap_pkg.sv
// Shared types and constants for the AXI4 ROM burst wrapper.
package rom_wrap_pkg;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_DATA, WR_RESP} state_t;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // A WRAP length is legal when LEN+1 is a power of two greater than one.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len != 8'd0) && ((len & (len + 8'd1)) == 8'd0);
  endfunction
endpackage

// File: rtl/rom_burst_wrapper_if.sv
// AXI4 slave-port bundle for rom_burst_wrapper; slave modport faces the wrapper.
interface rom_burst_wrapper_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     ARID_S;
  logic [ADDR_W-1:0]   ARADDR_S;
  logic [LEN_W-1:0]    ARLEN_S;
  logic [2:0]          ARSIZE_S;
  logic [1:0]          ARBURST_S;
  logic                ARVALID_S, ARREADY_S;
  logic [ID_W-1:0]     RID_S;
  logic [DATA_W-1:0]   RDATA_S;
  logic [1:0]          RRESP_S;
  logic                RLAST_S, RVALID_S, RREADY_S;
  logic [ID_W-1:0]     AWID_S;
  logic [ADDR_W-1:0]   AWADDR_S;
  logic [LEN_W-1:0]    AWLEN_S;
  logic [2:0]          AWSIZE_S;
  logic [1:0]          AWBURST_S;
  logic                AWVALID_S, AWREADY_S;
  logic [DATA_W-1:0]   WDATA_S;
  logic [DATA_W/8-1:0] WSTRB_S;
  logic                WLAST_S, WVALID_S, WREADY_S;
  logic [ID_W-1:0]     BID_S;
  logic [1:0]          BRESP_S;
  logic                BVALID_S, BREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S
  );
endinterface

// File: rtl/rom_burst_addr_gen.sv
// Next ROM word address for FIXED/INCR/WRAP bursts; flags WRAP lengths that are not legal.
module rom_burst_addr_gen
  import rom_wrap_pkg::*;
#(
  parameter int ROM_AW = 12,
  parameter int LEN_W  = 4
) (
  input  logic [ROM_AW-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_burst,
  output logic [ROM_AW-1:0] o_next_addr,
  output logic              o_wrap_illegal
);
  logic [ROM_AW-1:0] w_inc, w_mask;
  logic              w_wrap_ok;

  assign w_inc     = i_addr + 1'b1;
  assign w_mask    = ROM_AW'(i_len);
  assign w_wrap_ok = wrap_len_legal(8'(i_len));

  // Illegal WRAP and the reserved encoding both fall through to INCR.
  always_comb begin
    o_next_addr    = w_inc;
    o_wrap_illegal = 1'b0;
    case (i_burst)
      FIXED: o_next_addr = i_addr;
      WRAP: begin
        if (w_wrap_ok) o_next_addr = (i_addr & ~w_mask) | (w_inc & w_mask);
        else           o_wrap_illegal = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/rom_burst_wrapper.sv
// AXI4 read-burst slave in front of a synchronous ROM; writes are absorbed with SLVERR.
// Optional ROM_RANGE_CHECK_EN: beats at or above ROM_DEPTH return DECERR and skip the ROM read.
module rom_burst_wrapper
  import rom_wrap_pkg::*;
#(
  parameter int          ID_W      = 8,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 4,
  parameter int          ROM_AW    = 12,
  parameter int unsigned ROM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  rom_burst_wrapper_if.slave s_axi,
  output logic              ROM_enable,
  output logic              ROM_read,
  output logic [ROM_AW-1:0] ROM_address,
  input  logic [DATA_W-1:0] ROM_out
);
  localparam int BB = $clog2(DATA_W/8);

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rid, r_awid;
  logic [LEN_W-1:0]  r_len, r_beat;
  logic [1:0]        r_burst;
  logic [ROM_AW-1:0] r_addr;
  logic              r_err, r_oor, r_aw_pend;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_valid;

  logic [ROM_AW-1:0] w_ar_addr, w_ag_addr, w_next_addr, w_issue_addr;
  logic [LEN_W-1:0]  w_ag_len;
  logic [1:0]        w_ag_burst;
  logic              w_wrap_ill, w_oor, w_last, w_idle;
  logic              w_unused;

  assign w_idle    = (r_state == IDLE);
  assign w_ar_addr = s_axi.ARADDR_S[ROM_AW+BB-1:BB];
  assign w_last    = (r_beat == r_len);

  // In IDLE the generator sees the incoming AR so its wrap check is ready at handshake.
  assign w_ag_addr  = w_idle ? w_ar_addr : r_addr;
  assign w_ag_len   = w_idle ? s_axi.ARLEN_S : r_len;
  assign w_ag_burst = w_idle ? s_axi.ARBURST_S : r_burst;

  rom_burst_addr_gen #(.ROM_AW(ROM_AW), .LEN_W(LEN_W)) u_addr_gen (
    .i_addr        (w_ag_addr),
    .i_len         (w_ag_len),
    .i_burst       (w_ag_burst),
    .o_next_addr   (w_next_addr),
    .o_wrap_illegal(w_wrap_ill)
  );

  assign w_issue_addr = w_idle ? w_ar_addr : w_next_addr;

`ifdef ROM_RANGE_CHECK_EN
  assign w_oor = ({1'b0, w_issue_addr} >= (ROM_AW+1)'(ROM_DEPTH));
`else
  assign w_oor = 1'b0;
`endif

  assign w_unused = ^{s_axi.ARADDR_S, s_axi.AWADDR_S, s_axi.AWLEN_S, s_axi.AWSIZE_S,
                      s_axi.AWBURST_S, s_axi.WDATA_S, s_axi.WSTRB_S, 32'(ROM_DEPTH)};

  always_comb begin
    w_state_nxt     = r_state;
    s_axi.ARREADY_S = 1'b0;
    s_axi.AWREADY_S = 1'b0;
    s_axi.RVALID_S  = 1'b0;
    s_axi.RLAST_S   = 1'b0;
    s_axi.RID_S     = '0;
    s_axi.RDATA_S   = '0;
    s_axi.RRESP_S   = OKAY;
    s_axi.WREADY_S  = 1'b0;
    s_axi.BVALID_S  = 1'b0;
    s_axi.BID_S     = '0;
    s_axi.BRESP_S   = OKAY;
    ROM_enable      = 1'b0;
    ROM_read        = 1'b0;
    ROM_address     = '0;
    // Outputs drop the moment rst rises, not at the next clock.
    if (!rst) begin
      case (r_state)
        IDLE: begin
          s_axi.ARREADY_S = 1'b1;
          s_axi.AWREADY_S = 1'b1;
          if (s_axi.ARVALID_S) begin
            ROM_enable  = !w_oor;
            ROM_address = w_issue_addr;
            w_state_nxt = RD_BURST;
          end else if (s_axi.AWVALID_S) begin
            w_state_nxt = WR_DATA;
          end
        end
        RD_BURST: begin
          ROM_read        = 1'b1;
          s_axi.RVALID_S  = 1'b1;
          s_axi.RID_S     = r_rid;
          s_axi.RLAST_S   = w_last;
          s_axi.RDATA_S   = r_oor ? '0 : (r_hold_valid ? r_hold : ROM_out);
          s_axi.RRESP_S   = r_oor ? DECERR : (r_err ? SLVERR : OKAY);
          if (s_axi.RREADY_S) begin
            if (w_last) begin
              w_state_nxt = r_aw_pend ? WR_DATA : IDLE;
            end else begin
              ROM_enable  = !w_oor;
              ROM_address = w_issue_addr;
            end
          end
        end
        WR_DATA: begin
          s_axi.WREADY_S = 1'b1;
          if (s_axi.WVALID_S && s_axi.WLAST_S) w_state_nxt = WR_RESP;
        end
        WR_RESP: begin
          s_axi.BVALID_S = 1'b1;
          s_axi.BID_S    = r_awid;
          s_axi.BRESP_S  = SLVERR;
          if (s_axi.BREADY_S) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rid        <= '0;
      r_awid       <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_burst      <= '0;
      r_addr       <= '0;
      r_err        <= 1'b0;
      r_oor        <= 1'b0;
      r_aw_pend    <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_axi.ARVALID_S) begin
            r_rid        <= s_axi.ARID_S;
            r_len        <= s_axi.ARLEN_S;
            r_burst      <= s_axi.ARBURST_S;
            r_addr       <= w_ar_addr;
            r_beat       <= '0;
            r_err        <= (s_axi.ARSIZE_S != 3'(BB)) || w_wrap_ill || (s_axi.ARBURST_S == 2'b11);
            r_oor        <= w_oor;
            r_hold_valid <= 1'b0;
          end
          if (s_axi.AWVALID_S) begin
            r_awid    <= s_axi.AWID_S;
            r_aw_pend <= s_axi.ARVALID_S;
          end
        end
        RD_BURST: begin
          if (s_axi.RREADY_S) begin
            r_hold_valid <= 1'b0;
            if (w_last) begin
              r_aw_pend <= 1'b0;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_addr <= w_next_addr;
              r_oor  <= w_oor;
            end
          end else if (!r_hold_valid) begin
            // ROM_out is only valid one cycle after the read, so park it on the first stall cycle.
            r_hold       <= ROM_out;
            r_hold_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_burst_wrapper.sv
// Randomized bench for rom_burst_wrapper against a burst-address/response model and a ROM array.
module tb_rom_burst_wrapper;
  import rom_wrap_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_burst_wrapper_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus();

  logic        rom_en, rom_rd;
  logic [11:0] rom_a;
  logic [31:0] rom_q;

  rom_burst_wrapper #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .ROM_AW(12), .ROM_DEPTH(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (bus),
    .ROM_enable (rom_en),
    .ROM_read   (rom_rd),
    .ROM_address(rom_a),
    .ROM_out    (rom_q)
  );

  logic [31:0] rom_mem [4096];
  int en_cnt = 0;
  int n_chk  = 0;
  int n_err  = 0;

  // ROM macro model: data is only meaningful the cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    rom_q <= rom_en ? rom_mem[rom_a] : $urandom;
    if (rom_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready"}, bus.ARREADY_S, 0);
    chk({tag, "_awready"}, bus.AWREADY_S, 0);
    chk({tag, "_rvalid"},  bus.RVALID_S, 0);
    chk({tag, "_wready"},  bus.WREADY_S, 0);
    chk({tag, "_bvalid"},  bus.BVALID_S, 0);
    chk({tag, "_rom_en"},  rom_en, 0);
    chk({tag, "_rom_rd"},  rom_rd, 0);
    chk({tag, "_rom_a"},   rom_a, 0);
    chk({tag, "_rdata"},   bus.RDATA_S, 0);
    chk({tag, "_rid"},     bus.RID_S, 0);
    chk({tag, "_rresp"},   bus.RRESP_S, 0);
    chk({tag, "_bresp"},   bus.BRESP_S, 0);
  endtask

  // Word-address sequence and response of a burst, straight from the AXI rules.
  task automatic model_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, output int ea [16], output logic [1:0] er);
    int n, st, base;
    bit wrap_ok;
    n       = len + 1;
    st      = int'((addr >> 2) & 32'hFFF);
    wrap_ok = (n == 2) || (n == 4) || (n == 8) || (n == 16);
    er = (size != 3'd2 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) ? SLVERR : OKAY;
    base = (st / n) * n;
    for (int i = 0; i < 16; i++) begin
      if (burst == 2'b00)                ea[i] = st;
      else if (burst == 2'b10 && wrap_ok) ea[i] = base + ((st - base + i) % n);
      else                               ea[i] = (st + i) % 4096;
    end
  endtask

  task automatic wr_data(input logic [7:0] awid, input int nbeats);
    int en0;
    en0 = en_cnt;
    for (int b = 0; b < nbeats; b++) begin
      bus.WVALID_S = 1'b1;
      bus.WLAST_S  = (b == nbeats - 1);
      bus.WDATA_S  = $urandom;
      #1;
      chk("wready", bus.WREADY_S, 1);
      @(negedge clk);
    end
    bus.WVALID_S = 1'b0;
    bus.WLAST_S  = 1'b0;
    #1;
    chk("bvalid", bus.BVALID_S, 1);
    chk("bid",    bus.BID_S, awid);
    chk("bresp",  bus.BRESP_S, SLVERR);
    bus.BREADY_S = 1'b1;
    @(negedge clk);
    bus.BREADY_S = 1'b0;
    #1;
    chk("b_done_bvalid", bus.BVALID_S, 0);
    chk("b_done_idle",   bus.ARREADY_S, 1);
    chk("wr_no_rom",     en_cnt - en0, 0);
  endtask

  task automatic do_write(input logic [7:0] awid, input int nbeats);
    @(negedge clk);
    bus.AWVALID_S = 1'b1;
    bus.AWID_S    = awid;
    bus.AWADDR_S  = $urandom;
    bus.AWLEN_S   = 4'(nbeats - 1);
    #1;
    chk("awready", bus.AWREADY_S, 1);
    @(negedge clk);
    bus.AWVALID_S = 1'b0;
    wr_data(awid, nbeats);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int sb,
                         input int sn, input bit with_aw, input logic [7:0] awid);
    int ea [16];
    logic [1:0] er;
    int en0;
    model_burst(addr, len, size, burst, ea, er);
    @(negedge clk);
    en0 = en_cnt;
    bus.ARVALID_S = 1'b1;
    bus.ARID_S    = id;
    bus.ARADDR_S  = addr;
    bus.ARLEN_S   = 4'(len);
    bus.ARSIZE_S  = size;
    bus.ARBURST_S = burst;
    if (with_aw) begin
      bus.AWVALID_S = 1'b1;
      bus.AWID_S    = awid;
      bus.AWADDR_S  = $urandom;
    end
    #1;
    chk("arready", bus.ARREADY_S, 1);
    chk("ar_rom_en", rom_en, 1);
    chk("ar_rom_a", rom_a, ea[0]);
    if (with_aw) chk("aw_with_ar", bus.AWREADY_S, 1);
    @(negedge clk);
    bus.ARVALID_S = 1'b0;
    bus.AWVALID_S = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == sb) begin
        for (int s = 0; s < sn; s++) begin
          bus.RREADY_S = 1'b0;
          #1;
          chk("stall_rvalid", bus.RVALID_S, 1);
          chk("stall_rom_en", rom_en, 0);
          chk("stall_rdata",  bus.RDATA_S, rom_mem[ea[i]]);
          @(negedge clk);
        end
      end
      bus.RREADY_S = 1'b1;
      #1;
      chk("rvalid", bus.RVALID_S, 1);
      chk("rdata",  bus.RDATA_S, rom_mem[ea[i]]);
      chk("rresp",  bus.RRESP_S, er);
      chk("rid",    bus.RID_S, id);
      chk("rlast",  bus.RLAST_S, (i == len));
      if (i < len) begin
        chk("nxt_rom_en", rom_en, 1);
        chk("nxt_rom_a",  rom_a, ea[i+1]);
      end else begin
        chk("last_rom_en", rom_en, 0);
      end
      @(negedge clk);
    end
    bus.RREADY_S = 1'b0;
    #1;
    chk("rd_rom_count", en_cnt - en0, len + 1);
    if (with_aw) chk("rd_then_wready", bus.WREADY_S, 1);
    else         chk("rd_then_idle",   bus.ARREADY_S, 1);
    if (with_aw) wr_data(awid, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, sb;
    for (int i = 0; i < 4096; i++) rom_mem[i] = $urandom;
    bus.ARVALID_S = 0; bus.ARID_S = 0; bus.ARADDR_S = 0; bus.ARLEN_S = 0;
    bus.ARSIZE_S = 0; bus.ARBURST_S = 0; bus.RREADY_S = 0;
    bus.AWVALID_S = 0; bus.AWID_S = 0; bus.AWADDR_S = 0; bus.AWLEN_S = 0;
    bus.AWSIZE_S = 0; bus.AWBURST_S = 0;
    bus.WDATA_S = 0; bus.WSTRB_S = 0; bus.WLAST_S = 0; bus.WVALID_S = 0; bus.BREADY_S = 0;

    #1 rst = 1'b1;
    #2 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_read(8'h11, 32'h0000_0010, 0, 3'd2, INCR, -1, 0, 0, 8'h00);
    do_read(8'h22, 32'h0000_0100, 3, 3'd2, INCR, -1, 0, 0, 8'h00);
    do_read(8'h23, 32'h0000_0100, 3, 3'd2, INCR, 1, 3, 0, 8'h00);
    do_read(8'h33, 32'h0000_0108, 3, 3'd2, WRAP, -1, 0, 0, 8'h00);
    do_read(8'h34, 32'h0000_0108, 2, 3'd2, WRAP, -1, 0, 0, 8'h00);
    do_read(8'h35, 32'h0000_0040, 2, 3'd2, FIXED, 0, 2, 0, 8'h00);
    do_read(8'h36, 32'h0000_3FF8, 3, 3'd2, INCR, -1, 0, 0, 8'h00);
    do_read(8'h37, 32'h0000_0200, 1, 3'd1, 2'b11, -1, 0, 0, 8'h00);
    do_write(8'h5A, 2);
    do_read(8'h44, 32'h0000_0080, 3, 3'd2, INCR, 2, 1, 1, 8'hA5);

    // Reset in the middle of a read that also latched a write.
    @(negedge clk);
    bus.ARVALID_S = 1'b1; bus.ARID_S = 8'h77; bus.ARADDR_S = 32'h400;
    bus.ARLEN_S = 4'd7; bus.ARSIZE_S = 3'd2; bus.ARBURST_S = INCR;
    bus.AWVALID_S = 1'b1; bus.AWID_S = 8'h66;
    @(negedge clk);
    bus.ARVALID_S = 1'b0; bus.AWVALID_S = 1'b0; bus.RREADY_S = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midburst_rst");
    @(negedge clk);
    bus.RREADY_S = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_idle",   bus.ARREADY_S, 1);
    chk("post_rst_wready", bus.WREADY_S, 0);
    do_read(8'h78, 32'h0000_0020, 1, 3'd2, INCR, -1, 0, 0, 8'h00);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_write(8'($urandom), $urandom_range(1, 4));
      end else begin
        len = $urandom_range(0, 15);
        sb  = $urandom_range(0, len);
        do_read(8'($urandom), $urandom, len,
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
                2'($urandom_range(0, 3)), sb, $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0), 8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_burst_wrapper.md
Name: rom_burst_wrapper

Overview:
- AXI4 slave wrapper for a synchronous single-port ROM macro. Successor to the single-beat ROM slave.
- Supports parametrised widths, FIXED/INCR/WRAP read bursts at one beat per cycle with RREADY backpressure, and full write-burst absorption with an error response.
- Sits between the AXI interconnect slave port and the ROM macro (CS/OE/A/DO interface).

Parameters:
ID_W, 8, width of ARID/RID/AWID/BID
ADDR_W, 32, AXI address width
DATA_W, 32, data width; power of two, at least 32
LEN_W, 4, AxLEN width (max burst length 2^LEN_W beats)
ROM_AW, 12, ROM word-address width
ROM_DEPTH, 4096, valid ROM words; must be at most 2^ROM_AW

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  read address
ARVALID_S in 1; ARREADY_S out 1  read address handshake
RID_S out ID_W; RDATA_S out DATA_W; RRESP_S out 2; RLAST_S out 1  read data
RVALID_S out 1; RREADY_S in 1  read data handshake
AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID_W/ADDR_W/LEN_W/3/2  write address
AWVALID_S in 1; AWREADY_S out 1  write address handshake
WDATA_S in DATA_W; WSTRB_S in DATA_W/8; WLAST_S in 1; WVALID_S in 1; WREADY_S out 1  write data
BID_S out ID_W; BRESP_S out 2; BVALID_S out 1; BREADY_S in 1  write response
ROM_enable  out  1  ROM chip select; one read issued per cycle asserted
ROM_read  out  1  ROM output enable
ROM_address  out  ROM_AW  ROM word address
ROM_out  in  DATA_W  ROM data; valid only in the cycle after ROM_enable

Behaviour:
Reset:
- Single clock clk; rst is asynchronous, active-high.
- Asserting rst forces IDLE immediately, including mid-burst.
- All VALID/READY outputs, ROM_enable and ROM_read are 0; all ID, data and address outputs are 0; RRESP_S and BRESP_S are 2'b00.

States: IDLE, RD_BURST, WR_DATA, WR_RESP.

IDLE:
- ARREADY_S=AWREADY_S=1.
- If ARVALID_S: latch ID, LEN, BURST and the word address ARADDR_S[ROM_AW+B-1:B] (B=log2(DATA_W/8)).
- In the same cycle, drive ROM_enable=1 with the beat-0 address, then go to RD_BURST.
- Else if AWVALID_S: latch AWID, go to WR_DATA.
- Simultaneous AR and AW: read wins. AWREADY_S is still high, so the AW address is accepted and latched, and the write is served after the read completes.

RD_BURST:
- ROM_read=1 and RVALID_S=1. RID_S is the latched ID. RLAST_S=1 when beat_cnt==LEN.
- Latency from AR handshake to first RVALID_S is 1 cycle.
- RDATA_S comes from ROM_out, or from the hold register when hold_valid=1.
- RVALID_S high with RREADY_S low: capture ROM_out into the hold register (first stall cycle only), set hold_valid, issue no ROM read.
- On handshake of a non-last beat: increment beat_cnt, drive ROM_enable=1 with the next address, clear hold_valid.
- Sustained RREADY_S=1 gives one beat per cycle.
- On handshake of the last beat: go to IDLE, or to WR_DATA if a write AW was latched during the read's IDLE cycle.

Address update (word granularity):
- FIXED: hold the address.
- INCR: address+1, wrapping modulo 2^ROM_AW.
- WRAP: only the low log2(LEN+1) bits increment; the upper bits are held.
- WRAP with LEN not in {1,3,7,15}: handled as INCR, with RRESP_S=SLVERR on every beat.

Read response per beat:
- OKAY normally.
- SLVERR if ARSIZE_S != B, or on illegal WRAP; data is still returned.
- Reserved ARBURST 2'b11 is treated as INCR with SLVERR.

WR_DATA:
- WREADY_S=1; data is discarded and the ROM is never written.
- On WVALID_S && WLAST_S, go to WR_RESP.

WR_RESP:
- BVALID_S=1, BID_S is the latched AWID, BRESP_S=SLVERR.
- On BREADY_S, go to IDLE.

Optional Feature:
ROM_RANGE_CHECK_EN
- Defined: any beat whose word address is at least ROM_DEPTH returns RRESP_S=DECERR with RDATA_S=0; ROM_enable stays 0 for that beat, but timing is unchanged.
- Undefined: no range check; the address wraps modulo 2^ROM_AW; behaviour is as above.

Decomposition:
Shared package rom_wrap_pkg holds:
- state_t enum
- burst encodings FIXED/INCR/WRAP
- response constants OKAY/EXOKAY/SLVERR/DECERR

Sub-module rom_burst_addr_gen:
- combinational next word address from (addr, LEN, BURST)
- outputs a wrap_illegal flag

Test Plan:
- Single read: ARADDR=0x0000_0010, LEN=0, RREADY=1 -> ROM_address=0x004 in the handshake cycle; next cycle RVALID with RLAST=1, RDATA=ROM[4], RRESP=OKAY, RID=ARID.
- INCR read: ADDR=0x100, LEN=3, RREADY=1 -> ROM_address 0x040,0x041,0x042,0x043 on consecutive cycles; RVALID for 4 consecutive cycles; RLAST on the 4th.
- Backpressure: same burst, RREADY low for 3 cycles on beat 1 -> RDATA held at ROM[0x41], no ROM_enable during the stall; beats 2 and 3 follow back-to-back.
- WRAP read: ADDR=0x108, LEN=3 -> word addresses 0x042,0x043,0x040,0x041; WRAP with LEN=2 -> INCR order, RRESP=SLVERR on all 3 beats.
- Write: AWID=0x5A, LEN=1, two W beats -> WREADY for both beats; then BVALID, BRESP=SLVERR, BID=0x5A; ROM_enable never asserted.
- Simultaneous AR and AW, then rst asserted mid-burst -> read served first, write follows; on reset, all outputs go to 0 asynchronously and the next transaction starts cleanly from IDLE.
